// File: rtl/ldtu_hamm_pkg.sv
// Shared Hamming(38,32) SEC definitions for the LiTe-DTU oFIFO encoder and reader.
// Code bit i is Hamming position i+1; check bits sit at the power-of-two positions.
package ldtu_hamm_pkg;

    localparam int unsigned Nbits_ham  = 38;
    localparam int unsigned Nbits_data = 32;
    localparam int unsigned Nbits_syn  = 6;
    localparam int unsigned QDepth     = 4;
    localparam int unsigned CntBits    = 8;

    // Queue entry: decoded payload plus its correction status
    typedef struct packed {
        logic [Nbits_data-1:0] data;
        logic                  corr;
        logic                  uncorr;
    } hamm_word_t;

    function automatic logic f_is_check(input logic [5:0] p);
        return (p & (p - 6'd1)) == 6'd0;
    endfunction

    function automatic logic [Nbits_syn-1:0] f_syndrome(input logic [Nbits_ham-1:0] code);
        logic [Nbits_syn-1:0] s;
        s = '0;
        for (logic [5:0] i = 6'd0; i < 6'(Nbits_ham); i++) begin
            if (code[i]) s ^= i + 6'd1;
        end
        return s;
    endfunction

    function automatic logic [Nbits_data-1:0] f_extract(input logic [Nbits_ham-1:0] code);
        logic [Nbits_data-1:0] d;
        logic [5:0]            j;
        d = '0;
        j = 6'd0;
        for (logic [5:0] i = 6'd0; i < 6'(Nbits_ham); i++) begin
            if (!f_is_check(i + 6'd1)) begin
                d[j[4:0]] = code[i];
                j         = j + 6'd1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/ldtu_hamm_dec38.sv
// Combinational SEC correction and payload extraction for one registered code word.
module ldtu_hamm_dec38
    import ldtu_hamm_pkg::*;
(
    input  logic [Nbits_ham-1:0] code_i,
    input  logic [Nbits_syn-1:0] syn_i,
    output hamm_word_t           word_c_o
);

    logic [Nbits_ham-1:0] fixed;

    // Out-of-range syndromes pass the payload through untouched
    always_comb begin
        fixed    = code_i;
        word_c_o = '0;
        if (syn_i != '0 && syn_i <= 6'(Nbits_ham)) begin
            fixed         = code_i ^ (Nbits_ham'(1) << (syn_i - 6'd1));
            word_c_o.corr = 1'b1;
        end else if (syn_i > 6'(Nbits_ham)) begin
            word_c_o.uncorr = 1'b1;
        end
        word_c_o.data = f_extract(fixed);
    end

endmodule

// File: rtl/ldtu_ofifo_hamm_reader.sv
// oFIFO read controller: credit-based pops, two-stage SEC decode, output queue and
// saturating correction counters.
module ldtu_ofifo_hamm_reader
    import ldtu_hamm_pkg::*;
(
    input  logic                  CLK,
    input  logic                  rst_b,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic                  fifo_decode,
    input  logic [Nbits_ham-1:0]  fifo_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [Nbits_data-1:0] out_data,
    output logic                  out_corr,
    output logic                  out_uncorr,
    input  logic                  cnt_clear,
    output logic [CntBits-1:0]    sec_count,
    output logic [CntBits-1:0]    ded_count
);

    localparam int unsigned PTR_W = $clog2(QDepth);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned SUM_W = OCC_W + 1;

    logic                 pend_q, pend_d;
    logic                 s1_vld_q, s1_vld_d;
    logic [Nbits_ham-1:0] s1_code_q, s1_code_d;
    logic [Nbits_syn-1:0] s1_syn_q, s1_syn_d;
    hamm_word_t           mem_q [QDepth];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [CntBits-1:0]   sec_q, sec_d, ded_q, ded_d;

    logic [1:0]           in_flight_c;
    logic [SUM_W-1:0]     credit_c;
    logic                 rd_c, push_c, pop_c;
    hamm_word_t           dec_c;

    ldtu_hamm_dec38 u_dec (
        .code_i   (s1_code_q),
        .syn_i    (s1_syn_q),
        .word_c_o (dec_c)
    );

    // Reserve queue space at pop time so a word in flight always has a slot
    always_comb begin
        in_flight_c = 2'(pend_q) + 2'(s1_vld_q);
        credit_c    = SUM_W'(occ_q) + SUM_W'(in_flight_c);
        rd_c        = !fifo_empty && (credit_c < SUM_W'(QDepth));
        push_c      = s1_vld_q;
        pop_c       = (occ_q != '0) && out_ready;

        pend_d    = rd_c;
        s1_vld_d  = fifo_decode;
        s1_code_d = s1_code_q;
        s1_syn_d  = s1_syn_q;
        if (fifo_decode) begin
            s1_code_d = fifo_data;
            s1_syn_d  = f_syndrome(fifo_data);
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        occ_d    = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);

        // Clear wins over a same-cycle increment; counts stick at all-ones
        sec_d = sec_q;
        ded_d = ded_q;
        if (cnt_clear) begin
            sec_d = '0;
            ded_d = '0;
        end else if (push_c) begin
            if (dec_c.corr && sec_q != '1)   sec_d = sec_q + CntBits'(1);
            if (dec_c.uncorr && ded_q != '1) ded_d = ded_q + CntBits'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            pend_q    <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_code_q <= '0;
            s1_syn_q  <= '0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            sec_q     <= '0;
            ded_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            s1_vld_q  <= s1_vld_d;
            s1_code_q <= s1_code_d;
            s1_syn_q  <= s1_syn_d;
            if (push_c) mem_q[wr_ptr_q] <= dec_c;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            sec_q     <= sec_d;
            ded_q     <= ded_d;
        end
    end

    assign fifo_read  = rd_c;
    assign out_valid  = (occ_q != '0);
    assign out_data   = mem_q[rd_ptr_q].data;
    assign out_corr   = mem_q[rd_ptr_q].corr;
    assign out_uncorr = mem_q[rd_ptr_q].uncorr;
    assign sec_count  = sec_q;
    assign ded_count  = ded_q;

    a_no_overflow: assert property (@(posedge CLK) disable iff (!rst_b)
        !(push_c && occ_q == OCC_W'(QDepth)));

endmodule
